// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state type, add-3 constants and digit-count check for bin2bcd_seq
package bin2bcd_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // True when d BCD digits can hold every w-bit value (10^d > 2^w - 1)
    function automatic bit bcd_digits_ok(int w, int d);
        longint p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p > ((longint'(1) << w) - 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3_cell: one-digit shift-and-add-3 correction
//   din  : BCD digit before correction
//   dout : din + 3 when din >= 5, else din
module bcd_add3_cell
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter, one shift-and-add-3 step per clock
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   start : conversion request, honoured only when idle
//   bin   : W-bit binary value, captured when start is accepted
//   busy  : high while a conversion is running
//   done  : one-cycle strobe when bcd has just been updated
//   bcd   : D packed BCD digits, digit 0 in bits [3:0], held until the next done
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   bin,
    output logic           busy,
    output logic           done,
    output logic [4*D-1:0] bcd
);

    localparam int CW = $clog2(W + 1);

    if (!bcd_digits_ok(W, D)) begin : g_bad_d
        $error("bin2bcd_seq: D too small to represent every W-bit value");
    end

    state_t         state, state_d;
    logic [W-1:0]   sh;
    logic [4*D-1:0] acc, adj, acc_next;
    logic [CW-1:0]  cnt;
    logic           accept, last;

    for (genvar i = 0; i < D; i++) begin : g_dig
        bcd_add3_cell u_cell (
            .din  (acc[4*i +: 4]),
            .dout (adj[4*i +: 4])
        );
    end

    // Corrected digits shift up one bit while the binary MSB enters at the bottom
    assign acc_next = (adj << 1) | {{(4*D-1){1'b0}}, sh[W-1]};
    assign accept   = (state == IDLE) && start;
    assign last     = (state == SHIFT) && (cnt == CW'(1));
    assign busy     = (state == SHIFT);

    always_comb begin
        state_d = state;
        if (state == IDLE) state_d = start ? SHIFT : IDLE;
        else               state_d = last ? IDLE : SHIFT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sh    <= '0;
            acc   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            state <= state_d;
            done  <= last;
            if (accept) begin
                sh  <= bin;
                acc <= '0;
                cnt <= CW'(W);
            end else if (state == SHIFT) begin
                sh  <= sh << 1;
                acc <= acc_next;
                cnt <= cnt - CW'(1);
            end
            if (last) bcd <= acc_next;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: self-checking bench for bin2bcd_seq against a decimal-arithmetic model
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin = '0;
    logic        busy, done;
    logic [11:0] bcd;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.W(8), .D(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_bcd(int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single conversion from idle: 8 busy cycles, one done with the model result, then hold
    task automatic convert(input int v);
        int n = 0;
        int t = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'(v);
        @(negedge clk);
        start = 1'b0;
        bin   = 8'($urandom);
        while (!done && t < 40) begin
            if (busy) n++;
            t++;
            @(negedge clk);
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", n, 8);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("bcd", 32'(bcd), 32'(exp_bcd(v)));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("bcd_hold", 32'(bcd), 32'(exp_bcd(v)));
    endtask

    initial begin
        int sweep[7] = '{0, 9, 10, 99, 100, 128, 199};
        int dones;
        int last_t;
        int nxt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_bcd", 32'(bcd), 32'h000);
            @(negedge clk);
        end
        convert(255);
        repeat (3) @(negedge clk);
        chk("hold_255", 32'(bcd), 32'h255);
        foreach (sweep[i]) convert(sweep[i]);
        for (int v = 0; v < 256; v++) convert(v);
        for (int i = 0; i < 30; i++) convert(int'($urandom_range(255, 0)));
        // start re-pulsed mid-conversion must be ignored
        start = 1'b1;
        bin   = 8'd42;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        bin   = 8'd7;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                dones++;
                chk("ignore_bcd", 32'(bcd), 32'h042);
            end
            @(negedge clk);
        end
        chk("ignore_dones", dones, 1);
        chk("ignore_final", 32'(bcd), 32'h042);
        // reset in the middle of a conversion discards it
        start = 1'b1;
        bin   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'h000);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        chk("rst_no_done", dones, 0);
        chk("rst_bcd_after", 32'(bcd), 32'h000);
        // back-to-back with start held high
        start  = 1'b1;
        bin    = 8'd12;
        nxt    = 12;
        dones  = 0;
        last_t = -1;
        for (int t = 0; t < 60 && dones < 5; t++) begin
            @(negedge clk);
            if (done) begin
                chk("b2b_bcd", 32'(bcd), 32'(exp_bcd(nxt)));
                if (last_t >= 0) chk("b2b_period", t - last_t, 9);
                last_t = t;
                dones++;
                nxt = (nxt == 12) ? 250 : 12;
                bin = 8'(nxt);
            end
        end
        chk("b2b_count", dones, 5);
        start = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter for the filling-line counter displays. It takes a W-bit binary count, such as bottles filled or the current fill level, and runs the shift-and-add-3 algorithm one bit per clock. The result is D packed BCD digits for the seven-segment decoder stage downstream. Conversion is started by a one-cycle request and finishes with a one-cycle `done` strobe.

## Interface
- `W`, default 8: binary input width.
- `D`, default 3: number of BCD output digits. Must satisfy 10^D > 2^W − 1; otherwise elaboration fails with `$error`.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `bin`  in  W  binary value; captured on the edge that accepts `start`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle strobe: `bcd` has just been updated.
- `bcd`  out  4·D  result, digit 0 in bits [3:0]; holds its value until the next `done`.

## Operation
- Internal registers:
  - `sh` (W bits): binary shift register.
  - `acc` (4·D bits): BCD accumulator.
  - `cnt` (counts 0..W).
  - `bcd` output register.
  - State register.
- States and transitions:
  - IDLE → SHIFT when `start`=1. On that edge: `sh`←`bin`, `acc`←0, `cnt`←W.
  - SHIFT, per edge:
    - Each 4-bit digit of `acc` is corrected first: if the digit ≥ 5, add 3; otherwise leave it unchanged.
    - Then {`acc`,`sh`} shifts left by one. The MSB of `sh` enters bit 0 of `acc`.
    - `cnt` decrements by 1.
  - SHIFT → IDLE on the edge where `cnt`=1, i.e. the W-th shift. On that edge `bcd` loads the post-shift accumulator value and `done` is set.
- All corrections are 4-bit and never carry between digits; this holds given the constraint on D.
- `start` while SHIFT is ignored. It is not queued.
- `bin` is don't-care except on the accepting edge.
- `busy` equals (state==SHIFT).
- `done` is registered. It is high for exactly one cycle and clears on the following edge.
- `reset` takes priority over everything, including mid-conversion:
  - State ← IDLE, `busy`=0, `done`=0, `bcd`=0.
  - `sh`, `acc` and `cnt` ← 0.
  - A partial result is discarded and never appears on `bcd`.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=0.
- `start` accepted on edge k:
  - `busy`=1 from after edge k through edge k+W−1.
  - `busy`=0 and `done`=1 in the cycle after edge k+W.
  - The new `bcd` is valid in that same cycle.
- Latency is W cycles from the accept edge to `done` (8 for the defaults).
- `start` may be asserted in the `done` cycle. The state is IDLE then, so it is accepted at edge k+W+1.
- Minimum period is W+1 cycles per conversion.
- `start` and `reset` high together: reset wins, and there is no conversion.

## Structure
- Shared package `bin2bcd_pkg`:
  - State enum IDLE/SHIFT.
  - `BCD_ADJ_THRESH`=4'd5.
  - `BCD_ADJ_ADD`=4'd3.
- Sub-module `bcd_add3_cell`: purely combinational, 4-bit in/4-bit out, out = (in ≥ 5) ? in+3 : in.
  - Instantiated D times with a generate loop over the digits of `acc`.
- Top level holds only the FSM, the counter, the shift datapath and the output register.

## Test plan
- Reset then idle: no `start` for 20 cycles → `busy`=0, `done`=0, `bcd`=12'h000 throughout.
- `bin`=8'd255, 1-cycle `start` → `busy` high 8 cycles, then `done` for 1 cycle with `bcd`=12'h255. Afterwards `bcd` holds 12'h255.
- Value sweep 0, 9, 10, 99, 100, 128, 199 → `bcd` = 12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128, 12'h199. Then compare exhaustively for all 256 inputs against a reference model.
- `start` re-pulsed with `bin`=8'd7 at cycle 3 of a conversion of 8'd42 → ignored; result 12'h042, single `done`.
- `reset` asserted at cycle 5 of a conversion of 8'd200 → next cycle `busy`=0, `done`=0, `bcd`=12'h000; no `done` follows.
- Back-to-back: `start` held high continuously with `bin` alternating 8'd12 and 8'd250 → `done` every 9 cycles, `bcd` alternating 12'h012 and 12'h250.
